axi_rom_responder: RTL
======================

# axi_rom_responder

AXI4 read-only responder (slave) serving the AR/R channels issued by the instruction fetch master. It accepts one read address at a time and returns FIXED, INCR or WRAP bursts of 64-bit beats from an internal word array. The array is preloaded through a simple write port. The block is the memory-side end of the fetch interface, used in simulation and on-chip boot ROM.

## Interface
- `BASE_ADDR`, default 64'h0: byte address of word 0.
- `MEM_WORDS`, default 1024: number of 64-bit words in the array.
- `RD_LATENCY`, default 2: cycles from AR handshake to first `rvalid`. Legal range is ≥1.
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `s_axi_araddr` in 64: burst start byte address.
- `s_axi_arlen` in 8: beats minus 1.
- `s_axi_arsize` in 3: log2 bytes per beat.
- `s_axi_arburst` in 2: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
- `s_axi_arvalid` in 1 / `s_axi_arready` out 1: AR handshake.
- `s_axi_rdata` out 64: beat data, the full aligned word.
- `s_axi_rresp` out 2: 00 OKAY, 10 SLVERR, 11 DECERR.
- `s_axi_rlast` out 1: final beat of the burst.
- `s_axi_rvalid` out 1 / `s_axi_rready` in 1: R handshake.
- `load_en` in 1: write `load_data` to word `load_idx`.
- `load_idx` in $clog2(MEM_WORDS): word index to write.
- `load_data` in 64: word to write.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- The state machine has three states: IDLE, WAIT, BURST.
- **IDLE**
  - `arready`=1.
  - When `arvalid`&&`arready`, capture addr/len/size/burst, load the latency counter with RD_LATENCY-1, clear the beat counter, and go to WAIT.
- **WAIT**
  - Decrement the latency counter.
  - At 0, form beat 0 and go to BURST.
- **BURST**
  - Hold the registered beat with `rvalid`=1.
  - On `rvalid`&&`rready`:
    - If beat count equals len, deassert `rvalid` and go to IDLE.
    - Otherwise advance the address and form the next beat in the same edge, so beats stream back to back while `rready`=1.
- **Burst-level error, checked once at AR capture.** SLVERR is returned on every beat, with `rdata`=0, when any of these holds:
  - `arsize`>3;
  - `arburst`=3;
  - WRAP with len ∉ {1,3,7,15}.
- **Beat-level error, checked per beat.** DECERR with `rdata`=0 when addr < BASE_ADDR or word index (addr-BASE_ADDR)>>3 ≥ MEM_WORDS. A burst that runs off the array end returns OKAY beats, then DECERR beats.
- **Normal beat:** `rdata` = mem[(addr-BASE_ADDR)>>3]; `rresp`=OKAY.
- **Address advance**, with step = 1<<size. All arithmetic is 64-bit and wraps modulo 2^64.
  - FIXED: address unchanged.
  - INCR: next = (addr & ~(step-1)) + step. Only the first beat may be unaligned.
  - WRAP: wrap size W = (len+1)*step. next = (addr & ~(W-1)) | ((addr+step) & (W-1)).
- `rlast`=1 exactly on the beat where beat count equals len.
- **Load port**
  - A load writes the array at the edge.
  - A beat already registered is unaffected. Beats formed at a later edge see the new value.
  - Loads are legal in any state.

## Timing
- **Reset values:** `arready`=0, `rvalid`=0, `rlast`=0, `rresp`=00, `rdata`=0, `busy`=0, state IDLE. The array is not cleared.
- `arready` rises the first cycle after reset deasserts.
- All outputs are registered; no combinational path from inputs to outputs.
- If the AR handshake occurs at edge T, the first `rvalid` is visible after edge T+RD_LATENCY.
- Beat throughput is 1 per cycle with `rready` held high.
- While `rvalid`&&!`rready`, `rdata`/`rresp`/`rlast` stay stable.
- After the last R handshake at edge L:
  - `arready`=1 after edge L+1.
  - The next AR handshake can occur no earlier than edge L+2.
- `arready` is 0 in WAIT and BURST; `arvalid` is ignored there.
- **Reset mid-burst:** state goes to IDLE at that edge and `rvalid` drops. The remaining beats are never sent.

## Test plan
- **INCR burst:** load mem[i]=i for i=0..15. AR addr 0x0, len 7, size 3, INCR at edge T. Required: `rvalid` after T+2; beats 0..7 in order, all OKAY; `rlast` only on beat 7; `arready` returns after L+1.
- **Backpressure:** same burst with `rready` toggling 1,0,0,1,… Required: data held stable across stall cycles, no beat lost or duplicated, beats 0..7 delivered.
- **WRAP burst:** AR addr 0x18, len 3, size 3, WRAP. Required: words 3,0,1,2, then `rlast`. FIXED len 2 at 0x28: word 5 three times.
- **Errors:**
  - AR addr 8*(MEM_WORDS-2), len 3, INCR: OKAY, OKAY, DECERR, DECERR, with `rdata` 0 on the DECERR beats.
  - `arsize`=4: 1+len SLVERR beats.
  - WRAP len 2: 3 SLVERR beats.
- **Reset and load:**
  - Assert `reset` during beat 3 of an 8-beat burst: `rvalid`=0 and `busy`=0 after that edge; a new AR is accepted normally afterwards.
  - Load mem[5]=0xDEAD during a burst before beat 5 is formed: beat 5 returns 0xDEAD.

Source files
------------

// File: rtl/axi_rom_responder.sv
// AXI4 read-only responder for the instruction fetch path.
// Serves one AR burst at a time (FIXED/INCR/WRAP) from a preloadable 64-bit word array.
module axi_rom_responder #(
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter int          MEM_WORDS  = 1024,
  parameter int          RD_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [63:0]                  s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [63:0]                  s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  input  logic                         load_en,
  input  logic [$clog2(MEM_WORDS)-1:0] load_idx,
  input  logic [63:0]                  load_data,
  output logic                         busy
);
  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
  state_t state, state_d;

  logic [63:0] mem [MEM_WORDS];

  // burst context captured at AR time
  logic [63:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic        slverr_q;
  logic [31:0] lat_q;
  logic [7:0]  beat_q;

  logic        ar_hs, r_hs, form_first, form_next, finish, bad_burst;
  logic [63:0] step, wrap_w, next_addr, beat_addr, word_off;
  logic [7:0]  beat_idx;
  logic        in_range;

  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = s_axi_rvalid && s_axi_rready;
  assign busy  = (state != IDLE);

  // Burst legality is decided once, on the AR fields as presented
  assign bad_burst = (s_axi_arsize > 3'd3) || (s_axi_arburst == 2'd3) ||
                     ((s_axi_arburst == 2'd2) &&
                      !(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next state plus beat-formation strobes
  always_comb begin
    state_d    = state;
    form_first = 1'b0;
    form_next  = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE:  if (ar_hs) state_d = WAIT;
      WAIT:  if (lat_q == 32'd0) begin
               state_d    = BURST;
               form_first = 1'b1;
             end
      BURST: if (r_hs) begin
               if (beat_q == len_q) begin
                 state_d = IDLE;
                 finish  = 1'b1;
               end else begin
                 form_next = 1'b1;
               end
             end
      default: state_d = IDLE;
    endcase
  end

  // Address of the beat being formed; arithmetic wraps modulo 2^64
  always_comb begin
    step      = 64'd1 << size_q;
    wrap_w    = ({56'd0, len_q} + 64'd1) * step;
    next_addr = addr_q;
    case (burst_q)
      2'd1:    next_addr = (addr_q & ~(step - 64'd1)) + step;
      2'd2:    next_addr = (addr_q & ~(wrap_w - 64'd1)) | ((addr_q + step) & (wrap_w - 64'd1));
      default: next_addr = addr_q;
    endcase
    beat_addr = form_first ? addr_q : next_addr;
    beat_idx  = form_first ? 8'd0 : beat_q + 8'd1;
    word_off  = (beat_addr - BASE_ADDR) >> 3;
    in_range  = (beat_addr >= BASE_ADDR) && (word_off < 64'(MEM_WORDS));
  end

  // Preload port; not reset so contents survive a responder reset
  always_ff @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_data;
  end

  // AR capture, latency count and the registered R beat
  always_ff @(posedge clk) begin
    if (reset) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rdata   <= 64'd0;
      addr_q        <= 64'd0;
      len_q         <= 8'd0;
      size_q        <= 3'd0;
      burst_q       <= 2'd0;
      slverr_q      <= 1'b0;
      lat_q         <= 32'd0;
      beat_q        <= 8'd0;
    end else begin
      // ready only after a full cycle spent in IDLE, so it lags the last beat by one edge
      s_axi_arready <= (state == IDLE) && (state_d == IDLE);
      if (ar_hs) begin
        addr_q   <= s_axi_araddr;
        len_q    <= s_axi_arlen;
        size_q   <= s_axi_arsize;
        burst_q  <= s_axi_arburst;
        slverr_q <= bad_burst;
        lat_q    <= 32'(RD_LATENCY - 1);
        beat_q   <= 8'd0;
      end
      if (state == WAIT && lat_q != 32'd0) lat_q <= lat_q - 32'd1;
      if (form_first || form_next) begin
        addr_q       <= beat_addr;
        beat_q       <= beat_idx;
        s_axi_rvalid <= 1'b1;
        s_axi_rlast  <= (beat_idx == len_q);
        if (slverr_q) begin
          s_axi_rdata <= 64'd0;
          s_axi_rresp <= RESP_SLVERR;
        end else if (!in_range) begin
          s_axi_rdata <= 64'd0;
          s_axi_rresp <= RESP_DECERR;
        end else begin
          s_axi_rdata <= mem[word_off[AW-1:0]];
          s_axi_rresp <= RESP_OKAY;
        end
      end
      if (finish) begin
        s_axi_rvalid <= 1'b0;
        s_axi_rlast  <= 1'b0;
      end
    end
  end
endmodule
